// File: rtl/register_demultiplexer.sv
// register_demultiplexer
// Write-side steering of the ALU result bus. A 2-bit destination code routes
// data_in to register A, register B, a valid/ready output port, or the
// program-counter load path. Every write lands on the rising edge where we=1
// and is visible on the outputs right after that edge.
//
// The output port holds a single entry. While it is FULL and the device is not
// ready, a further port write is refused and busy tells the decoder to hold
// sel/data_in/we. Register and PC writes never stall.

module register_demultiplexer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic [1:0]       sel,
    input  logic             we,
    output logic             busy,
    output logic [WIDTH-1:0] reg_a,
    output logic [WIDTH-1:0] reg_b,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             pc_load,
    output logic [WIDTH-1:0] pc_addr
);

    // Destination codes driven by the instruction decoder.
    localparam logic [1:0] SEL_REG_A = 2'd0;
    localparam logic [1:0] SEL_REG_B = 2'd1;
    localparam logic [1:0] SEL_PORT  = 2'd2;
    localparam logic [1:0] SEL_PC    = 2'd3;

    // Output port occupancy: EMPTY has nothing to deliver, FULL holds out_data.
    typedef enum logic {
        PORT_EMPTY = 1'b0,
        PORT_FULL  = 1'b1
    } port_state_t;

    port_state_t      port_state_q, port_state_d;
    logic [WIDTH-1:0] out_data_q,   out_data_d;
    logic [WIDTH-1:0] reg_a_q,      reg_a_d;
    logic [WIDTH-1:0] reg_b_q,      reg_b_d;
    logic             pc_load_q,    pc_load_d;
    logic [WIDTH-1:0] pc_addr_q,    pc_addr_d;

    logic write_a;
    logic write_b;
    logic write_port;
    logic write_pc;
    logic port_stall;

    // Decode the write strobe into one request per destination, and flag the
    // single case where a port write has to wait for the device.
    always_comb begin
        write_a    = we && (sel == SEL_REG_A);
        write_b    = we && (sel == SEL_REG_B);
        write_port = we && (sel == SEL_PORT);
        write_pc   = we && (sel == SEL_PC);
        port_stall = write_port && (port_state_q == PORT_FULL) && !out_ready;
    end

    // Registers A and B simply capture data_in when addressed.
    always_comb begin
        reg_a_d = reg_a_q;
        reg_b_d = reg_b_q;
        if (write_a) begin
            reg_a_d = data_in;
        end
        if (write_b) begin
            reg_b_d = data_in;
        end
    end

    // PC load: the pulse is rebuilt every cycle so it can only last one cycle
    // per write, while the address is kept until the next PC write.
    always_comb begin
        pc_load_d = write_pc;
        pc_addr_d = pc_addr_q;
        if (write_pc) begin
            pc_addr_d = data_in;
        end
    end

    // Output port next state. A delivery (FULL and ready) and a new write may
    // happen on the same edge, in which case the port refills and stays FULL.
    // out_data keeps its last value after draining.
    always_comb begin
        port_state_d = port_state_q;
        out_data_d   = out_data_q;
        unique case (port_state_q)
            PORT_EMPTY: begin
                if (write_port) begin
                    out_data_d   = data_in;
                    port_state_d = PORT_FULL;
                end
            end
            PORT_FULL: begin
                if (out_ready) begin
                    if (write_port) begin
                        out_data_d   = data_in;
                        port_state_d = PORT_FULL;
                    end else begin
                        port_state_d = PORT_EMPTY;
                    end
                end
            end
            default: begin
                port_state_d = PORT_EMPTY;
            end
        endcase
    end

    // State register for all destinations; reset discards any pending output.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            port_state_q <= PORT_EMPTY;
            out_data_q   <= '0;
            reg_a_q      <= '0;
            reg_b_q      <= '0;
            pc_load_q    <= 1'b0;
            pc_addr_q    <= '0;
        end else begin
            port_state_q <= port_state_d;
            out_data_q   <= out_data_d;
            reg_a_q      <= reg_a_d;
            reg_b_q      <= reg_b_d;
            pc_load_q    <= pc_load_d;
            pc_addr_q    <= pc_addr_d;
        end
    end

    // Drive the ports from the state registers; busy is the live stall flag.
    always_comb begin
        busy      = port_stall;
        reg_a     = reg_a_q;
        reg_b     = reg_b_q;
        out_data  = out_data_q;
        out_valid = (port_state_q == PORT_FULL);
        pc_load   = pc_load_q;
        pc_addr   = pc_addr_q;
    end

endmodule

// File: tb/tb_register_demultiplexer.sv
// tb_register_demultiplexer
// Directed vector table, an asynchronous reset check mid-handshake, then
// random traffic compared against a behavioural model of the four destinations.

module tb_register_demultiplexer;

    localparam int WIDTH = 4;

    logic             clk;
    logic             reset;
    logic [WIDTH-1:0] data_in;
    logic [1:0]       sel;
    logic             we;
    logic             busy;
    logic [WIDTH-1:0] reg_a;
    logic [WIDTH-1:0] reg_b;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             pc_load;
    logic [WIDTH-1:0] pc_addr;

    int checks_done;
    int checks_failed;

    register_demultiplexer #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .data_in   (data_in),
        .sel       (sel),
        .we        (we),
        .busy      (busy),
        .reg_a     (reg_a),
        .reg_b     (reg_b),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .pc_load   (pc_load),
        .pc_addr   (pc_addr)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic       we;
        logic [1:0] sel;
        logic [3:0] din;
        logic       rdy;
        logic       exp_busy;
        logic [3:0] exp_a;
        logic [3:0] exp_b;
        logic [3:0] exp_od;
        logic       exp_ov;
        logic       exp_pl;
        logic [3:0] exp_pa;
    } vec_t;

    localparam int NUM_VECS = 18;
    vec_t vecs [NUM_VECS];

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks_done++;
        if (actual !== expected) begin
            checks_failed++;
            $display("[TB] FAIL %s: actual=%0h expected=%0h at t=%0t",
                     name, actual, expected, $time);
        end
    endtask

    task automatic apply_stimulus(input logic w, input logic [1:0] s,
                                  input logic [3:0] d, input logic r);
        we        = w;
        sel       = s;
        data_in   = d;
        out_ready = r;
    endtask

    task automatic check_all_outputs(input string tag, input logic [3:0] a,
                                     input logic [3:0] b, input logic [3:0] od,
                                     input logic ov, input logic pl,
                                     input logic [3:0] pa);
        check_output({tag, " reg_a"},     32'(reg_a),     32'(a));
        check_output({tag, " reg_b"},     32'(reg_b),     32'(b));
        check_output({tag, " out_data"},  32'(out_data),  32'(od));
        check_output({tag, " out_valid"}, 32'(out_valid), 32'(ov));
        check_output({tag, " pc_load"},   32'(pc_load),   32'(pl));
        check_output({tag, " pc_addr"},   32'(pc_addr),   32'(pa));
    endtask

    // Behavioural reference state for the random phase.
    logic [3:0] m_a, m_b, m_od, m_pa;
    logic       m_ov, m_pl;

    initial begin
        checks_done   = 0;
        checks_failed = 0;

        //                we  sel  din   rdy  busy  a     b     od    ov   pl   pa
        vecs[0]  = '{1'b1, 2'd0, 4'h5, 1'b0, 1'b0, 4'h5, 4'h0, 4'h0, 1'b0, 1'b0, 4'h0};
        vecs[1]  = '{1'b1, 2'd1, 4'hC, 1'b0, 1'b0, 4'h5, 4'hC, 4'h0, 1'b0, 1'b0, 4'h0};
        vecs[2]  = '{1'b1, 2'd3, 4'h7, 1'b0, 1'b0, 4'h5, 4'hC, 4'h0, 1'b0, 1'b1, 4'h7};
        vecs[3]  = '{1'b0, 2'd3, 4'h7, 1'b0, 1'b0, 4'h5, 4'hC, 4'h0, 1'b0, 1'b0, 4'h7};
        vecs[4]  = '{1'b1, 2'd3, 4'h1, 1'b0, 1'b0, 4'h5, 4'hC, 4'h0, 1'b0, 1'b1, 4'h1};
        vecs[5]  = '{1'b1, 2'd3, 4'h2, 1'b0, 1'b0, 4'h5, 4'hC, 4'h0, 1'b0, 1'b1, 4'h2};
        vecs[6]  = '{1'b0, 2'd0, 4'h0, 1'b0, 1'b0, 4'h5, 4'hC, 4'h0, 1'b0, 1'b0, 4'h2};
        vecs[7]  = '{1'b1, 2'd2, 4'h3, 1'b0, 1'b0, 4'h5, 4'hC, 4'h3, 1'b1, 1'b0, 4'h2};
        vecs[8]  = '{1'b1, 2'd2, 4'hF, 1'b0, 1'b1, 4'h5, 4'hC, 4'h3, 1'b1, 1'b0, 4'h2};
        vecs[9]  = '{1'b1, 2'd2, 4'hF, 1'b1, 1'b0, 4'h5, 4'hC, 4'hF, 1'b1, 1'b0, 4'h2};
        vecs[10] = '{1'b0, 2'd2, 4'hF, 1'b1, 1'b0, 4'h5, 4'hC, 4'hF, 1'b0, 1'b0, 4'h2};
        vecs[11] = '{1'b1, 2'd2, 4'h6, 1'b0, 1'b0, 4'h5, 4'hC, 4'h6, 1'b1, 1'b0, 4'h2};
        vecs[12] = '{1'b1, 2'd0, 4'h9, 1'b0, 1'b0, 4'h9, 4'hC, 4'h6, 1'b1, 1'b0, 4'h2};
        vecs[13] = '{1'b1, 2'd1, 4'hA, 1'b0, 1'b0, 4'h9, 4'hA, 4'h6, 1'b1, 1'b0, 4'h2};
        vecs[14] = '{1'b1, 2'd3, 4'hB, 1'b0, 1'b0, 4'h9, 4'hA, 4'h6, 1'b1, 1'b1, 4'hB};
        vecs[15] = '{1'b0, 2'd0, 4'h0, 1'b0, 1'b0, 4'h9, 4'hA, 4'h6, 1'b1, 1'b0, 4'hB};
        vecs[16] = '{1'b0, 2'd0, 4'h0, 1'b1, 1'b0, 4'h9, 4'hA, 4'h6, 1'b0, 1'b0, 4'hB};
        vecs[17] = '{1'b0, 2'd2, 4'h4, 1'b1, 1'b0, 4'h9, 4'hA, 4'h6, 1'b0, 1'b0, 4'hB};

        // Power-on reset.
        reset = 1'b1;
        apply_stimulus(1'b0, 2'd0, 4'h0, 1'b0);
        #2;
        check_all_outputs("por", 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 4'h0);
        check_output("por busy", 32'(busy), 32'd0);
        #10;
        reset = 1'b0;

        // Directed vectors: busy checked before the edge, state after it.
        for (int i = 0; i < NUM_VECS; i++) begin
            apply_stimulus(vecs[i].we, vecs[i].sel, vecs[i].din, vecs[i].rdy);
            #1;
            check_output($sformatf("vec%0d busy", i), 32'(busy), 32'(vecs[i].exp_busy));
            @(posedge clk);
            #1;
            check_all_outputs($sformatf("vec%0d", i), vecs[i].exp_a, vecs[i].exp_b,
                              vecs[i].exp_od, vecs[i].exp_ov, vecs[i].exp_pl,
                              vecs[i].exp_pa);
        end

        // Asynchronous reset while the port holds undelivered data.
        apply_stimulus(1'b1, 2'd0, 4'hA, 1'b0);
        @(posedge clk);
        #1;
        apply_stimulus(1'b1, 2'd2, 4'h5, 1'b0);
        @(posedge clk);
        #1;
        check_output("prereset reg_a", 32'(reg_a), 32'hA);
        check_output("prereset out_valid", 32'(out_valid), 32'd1);
        apply_stimulus(1'b1, 2'd2, 4'h7, 1'b0);
        #3;
        reset = 1'b1;
        #1;
        check_all_outputs("async_rst", 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 4'h0);
        check_output("async_rst busy", 32'(busy), 32'd0);
        apply_stimulus(1'b0, 2'd0, 4'h0, 1'b0);
        #2;
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_all_outputs("post_rst", 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 4'h0);

        // Random traffic against the reference model.
        m_a  = 4'h0;
        m_b  = 4'h0;
        m_od = 4'h0;
        m_ov = 1'b0;
        m_pl = 1'b0;
        m_pa = 4'h0;
        for (int n = 0; n < 400; n++) begin
            logic       r_we;
            logic [1:0] r_sel;
            logic [3:0] r_d;
            logic       r_rdy;
            logic       exp_busy;
            logic       accepted;
            r_we  = ($urandom_range(0, 3) != 0);
            r_sel = 2'($urandom_range(0, 3));
            r_d   = 4'($urandom_range(0, 15));
            r_rdy = ($urandom_range(0, 1) == 1);
            apply_stimulus(r_we, r_sel, r_d, r_rdy);
            #1;
            exp_busy = r_we && (r_sel == 2'd2) && m_ov && !r_rdy;
            check_output("rnd busy", 32'(busy), 32'(exp_busy));

            m_pl = r_we && (r_sel == 2'd3);
            if (m_pl) m_pa = r_d;
            if (r_we && r_sel == 2'd0) m_a = r_d;
            if (r_we && r_sel == 2'd1) m_b = r_d;
            accepted = r_we && (r_sel == 2'd2) && (!m_ov || r_rdy);
            if (accepted) begin
                m_od = r_d;
                m_ov = 1'b1;
            end else if (m_ov && r_rdy) begin
                m_ov = 1'b0;
            end

            @(posedge clk);
            #1;
            check_all_outputs("rnd", m_a, m_b, m_od, m_ov, m_pl, m_pa);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks_done, checks_failed);
        $finish;
    end

endmodule

// File: doc/register_demultiplexer.md
Name: register_demultiplexer

Overview:
- Write-side counterpart of the CPU's source multiplexer: takes the single ALU result bus and steers it to one of four destinations, selected by a 2-bit destination code.
- Destinations are register A, register B, the output port (valid/ready handshake) and the program-counter load path (one-cycle pulse).
- Sits between the ALU result and the architectural state; the instruction decoder drives sel/we.

Parameters:
WIDTH, 4, data bus and destination register width

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  asynchronous, active-high; clears all state immediately
data_in  input  WIDTH  ALU result to be written
sel  input  2  destination: 0=reg A, 1=reg B, 2=output port, 3=PC load
we  input  1  write strobe, sampled on rising clk
busy  output  1  combinational stall: output-port write cannot be accepted this cycle
reg_a  output  WIDTH  register A contents
reg_b  output  WIDTH  register B contents
out_data  output  WIDTH  output port data, stable while out_valid=1
out_valid  output  1  output port holds undelivered data
out_ready  input  1  output device accepts out_data this cycle
pc_load  output  1  one-cycle pulse: load PC from pc_addr
pc_addr  output  WIDTH  PC load target, valid when pc_load=1

Behaviour:
- Reset (async assert, any time): reg_a=0, reg_b=0, out_data=0, out_valid=0, pc_load=0, pc_addr=0. busy evaluates to 0 because out_valid=0. Reset mid-handshake discards pending output data.
- All writes take effect on the rising edge where we=1. Latency is 1 cycle: the new value is visible on the outputs after that edge.
- we=0: no destination changes. pc_load=0 next cycle. The output handshake still progresses.
- sel=0: reg_a <= data_in. sel=1: reg_b <= data_in. No other destination is touched.
- sel=3: pc_addr <= data_in and pc_load <= 1 for exactly one cycle.
  - pc_load is 0 in every cycle not immediately following a sel=3 write.
  - Back-to-back sel=3 writes give consecutive pulses, each carrying its own pc_addr.
- Output port is a 2-state machine, EMPTY (out_valid=0) and FULL (out_valid=1):
  - EMPTY, we & sel=2: out_data <= data_in, move to FULL.
  - FULL, out_ready=1, no write: move to EMPTY. out_data keeps its last value.
  - FULL, out_ready=1, we & sel=2: same-edge drain and refill. out_data <= data_in, stay FULL.
  - FULL, out_ready=0: out_data and out_valid hold. A we & sel=2 write is rejected and no state changes.
- busy = we & (sel==2) & out_valid & ~out_ready, purely combinational.
  - The decoder must hold sel/data_in/we while busy=1.
  - busy is never asserted for sel≠2.
- out_ready while EMPTY is ignored.
- Writes to A, B or PC are never stalled, including while the port is FULL.
- Widths: data_in is copied unmodified to the destination; no arithmetic and no truncation.

Test Plan:
- Reset: assert reset mid-cycle with out_valid=1 and reg_a=4'b1010 -> all outputs 0 immediately, before the next clk edge.
- Register writes: we=1, sel=0, data_in=4'b0101; then sel=1, data_in=4'b1100 -> after the two edges reg_a=0101, reg_b=1100, out_valid=0, pc_load never 1.
- PC pulse: sel=3, data_in=4'b0111 for one cycle, then we=0 -> pc_load=1 with pc_addr=0111 for exactly one cycle, then pc_load=0 and pc_addr holds 0111. Two consecutive sel=3 writes (0001, 0010) -> two pulses with the matching addresses.
- Output stall: write sel=2, data 4'b0011 with out_ready=0; next cycle write sel=2, data 4'b1111 -> out_data=0011, out_valid=1, busy=1. Raise out_ready while data 1111 is still held -> busy=0, out_data=1111 after that edge, out_valid stays 1.
- Drain: FULL with out_data=1111, we=0, out_ready=1 for one cycle -> out_valid=0, out_data stays 1111, busy=0.
- Non-stalled writes while FULL: out_ready=0, sel=0, data 4'b1001 -> reg_a=1001, busy=0, out_data unchanged.
